// File: rtl/rect_pkg.sv
// Shared types and constants for the multi-box rectangle overlay.
// The optional RECT_BLINK_EN build lives in rect_overlay_multi.sv.
package rect_pkg;
   localparam int AW_DEF    = 10;
   localparam int PW_DEF    = 10;
   localparam int THICK_MAX = 15;
   localparam int LATENCY   = 2;

   typedef struct packed {
      logic [AW_DEF-1:0] top;
      logic [AW_DEF-1:0] bottom;
      logic [AW_DEF-1:0] left;
      logic [AW_DEF-1:0] right;
      logic              en;
   } box_t;
endpackage

// File: rtl/rect_hit.sv
// Combinational border test for one box; inclusive bounds, no wrap.
module rect_hit
   import rect_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int THICK = 4
) (
   input  logic [AW-1:0] i_row,
   input  logic [AW-1:0] i_col,
   input  box_t          i_box,
   output logic          o_hit
);
   localparam int AW1 = AW + 1;

   logic [AW1-1:0] w_r, w_c, w_t, w_b, w_l, w_rt, w_th;
   logic           w_inside, w_edge;

   assign w_r  = AW1'(i_row);
   assign w_c  = AW1'(i_col);
   assign w_t  = AW1'(i_box.top);
   assign w_b  = AW1'(i_box.bottom);
   assign w_l  = AW1'(i_box.left);
   assign w_rt = AW1'(i_box.right);
   assign w_th = AW1'(THICK);

   // An inverted box fails the range test on its own, so it draws nothing.
   assign w_inside = i_box.en && (w_t <= w_b) && (w_l <= w_rt) &&
                     (w_r >= w_t) && (w_r <= w_b) && (w_c >= w_l) && (w_c <= w_rt);

   // "x > hi-THICK" rewritten as "x+THICK > hi" keeps everything non-negative.
   assign w_edge = (w_r < w_t + w_th) || (w_r + w_th > w_b) ||
                   (w_c < w_l + w_th) || (w_c + w_th > w_rt);

   assign o_hit = w_inside && w_edge;
endmodule

// File: rtl/rect_overlay_multi.sv
// Draws up to NUM_BOX rectangle outlines on a pixel stream, 2-cycle latency.
// Define RECT_BLINK_EN to add the blink_mask input and a 6-bit frame counter.
module rect_overlay_multi
   import rect_pkg::*;
#(
   parameter int             NUM_BOX  = 4,
   parameter int             AW       = AW_DEF,
   parameter int             PW       = PW_DEF,
   parameter int             THICK    = 4,
   parameter logic [PW-1:0]  LINE_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [AW-1:0]      Row,
   input  logic [AW-1:0]      Col,
   input  logic [PW-1:0]      GRAY2BW,
   input  logic               wr_en,
   input  logic [2:0]         wr_idx,
   input  logic [2*AW-1:0]    wr_row,
   input  logic [2*AW-1:0]    wr_col,
   input  logic               wr_box_en,
`ifdef RECT_BLINK_EN
   input  logic [NUM_BOX-1:0] blink_mask,
`endif
   output logic               out_valid,
   output logic [PW-1:0]      oBWrgb,
   output logic [NUM_BOX-1:0] active_mask
);
   logic               w_commit;
   box_t               r_shadow [NUM_BOX];
   box_t               r_active [NUM_BOX];
   logic               r_pend   [NUM_BOX];
   box_t               w_box    [NUM_BOX];
   logic [NUM_BOX-1:0] w_hit;
   logic [NUM_BOX-1:0] w_draw;
   logic [NUM_BOX-1:0] r_hit_s1;
   logic [PW-1:0]      r_pix_s1;
   logic [PW-1:0]      r_out;
   logic [LATENCY:1]   r_vld_pipe;

   assign w_commit = in_valid && (Row == '0) && (Col == '0);

`ifdef RECT_BLINK_EN
   // Starts at all-ones so the first commit after reset begins frame 0.
   logic [5:0] r_frame_cnt;
   logic [5:0] w_frame;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_frame_cnt <= '1;
      else if (w_commit) r_frame_cnt <= r_frame_cnt + 6'd1;
   end

   assign w_frame = w_commit ? r_frame_cnt + 6'd1 : r_frame_cnt;
   assign w_draw  = ~(blink_mask & {NUM_BOX{w_frame[5]}});
`else
   assign w_draw  = '1;
`endif

   generate
      for (genvar g = 0; g < NUM_BOX; g++) begin : g_box
         // The commit pixel already sees the freshly committed box.
         assign w_box[g]       = (w_commit && r_pend[g]) ? r_shadow[g] : r_active[g];
         assign active_mask[g] = r_active[g].en;

         // A write landing on the commit cycle wins the pending flag back.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_shadow[g] <= '0;
               r_active[g] <= '0;
               r_pend[g]   <= 1'b0;
            end else begin
               if (w_commit && r_pend[g]) begin
                  r_active[g] <= r_shadow[g];
                  r_pend[g]   <= 1'b0;
               end
               if (wr_en && (wr_idx == 3'(g))) begin
                  r_shadow[g] <= '{top:    wr_row[AW-1:0],  bottom: wr_row[2*AW-1:AW],
                                   left:   wr_col[AW-1:0],  right:  wr_col[2*AW-1:AW],
                                   en:     wr_box_en};
                  r_pend[g]   <= 1'b1;
               end
            end
         end

         rect_hit #(.AW(AW), .THICK(THICK)) u_hit (
            .i_row (Row),
            .i_col (Col),
            .i_box (w_box[g]),
            .o_hit (w_hit[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_s1   <= '0;
         r_pix_s1   <= '0;
         r_out      <= '0;
         r_vld_pipe <= '0;
      end else begin
         r_hit_s1   <= w_hit & w_draw;
         r_pix_s1   <= GRAY2BW;
         r_vld_pipe <= {r_vld_pipe[LATENCY-1:1], in_valid};
         // Output holds its last value across invalid slots.
         if (r_vld_pipe[1]) r_out <= (|r_hit_s1) ? LINE_VAL : r_pix_s1;
      end
   end

   assign oBWrgb    = r_out;
   assign out_valid = r_vld_pipe[LATENCY];
endmodule

// File: tb/tb_rect_overlay_multi.sv
// Scoreboard bench for rect_overlay_multi; expected pixels queued at drive time.
module tb_rect_overlay_multi;
   localparam int NB = 4;
   localparam int AW = 10;
   localparam int PW = 10;
   localparam int T  = 4;
   localparam logic [PW-1:0] LV = '0;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [AW-1:0]   Row, Col;
   logic [PW-1:0]   GRAY2BW;
   logic            wr_en;
   logic [2:0]      wr_idx;
   logic [2*AW-1:0] wr_row, wr_col;
   logic            wr_box_en;
   logic [NB-1:0]   blink_mask;
   logic            out_valid;
   logic [PW-1:0]   oBWrgb;
   logic [NB-1:0]   active_mask;

   always #5 clk = ~clk;

   rect_overlay_multi #(.NUM_BOX(NB), .AW(AW), .PW(PW), .THICK(T), .LINE_VAL(LV)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .Row         (Row),
      .Col         (Col),
      .GRAY2BW     (GRAY2BW),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .wr_box_en   (wr_box_en),
`ifdef RECT_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .out_valid   (out_valid),
      .oBWrgb      (oBWrgb),
      .active_mask (active_mask)
   );

   typedef struct { int t, b, l, r; bit en; } mbox_t;
   mbox_t         m_sh  [NB];
   mbox_t         m_act [NB];
   bit            m_pend[NB];
   int            m_fcnt;
   logic [PW-1:0] q[$];
   int            n_vec = 0, n_err = 0;

   bit wq; int wi, wt, wb, wl, wr; bit wen;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit m_hit(input int i, input int r, input int c);
      mbox_t b = m_act[i];
      if (!b.en) return 0;
`ifdef RECT_BLINK_EN
      if (blink_mask[i] && ((m_fcnt & 32) != 0)) return 0;
`endif
      if (r < b.t || r > b.b || c < b.l || c > b.r) return 0;
      return (r < b.t + T) || (r > b.b - T) || (c < b.l + T) || (c > b.r - T);
   endfunction

   function automatic logic [NB-1:0] m_mask();
      logic [NB-1:0] m = '0;
      for (int i = 0; i < NB; i++) m[i] = m_act[i].en;
      return m;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < NB; i++) begin
         m_sh[i] = '{0, 0, 0, 0, 1'b0}; m_act[i] = '{0, 0, 0, 0, 1'b0}; m_pend[i] = 0;
      end
      m_fcnt = -1;
      q.delete();
   endtask

   task automatic wreq(input int idx, input int t, input int b, input int l, input int r, input bit en);
      wq = 1; wi = idx; wt = t; wb = b; wl = l; wr = r; wen = en;
   endtask

   // One pixel slot: model commits first, then samples, then takes the write.
   task automatic drive(input bit v, input int r, input int c);
      logic [PW-1:0] g;
      bit            hit;
      @(negedge clk);
      g = PW'($urandom_range(1, 1023));
      in_valid = v; Row = AW'(r); Col = AW'(c); GRAY2BW = g;
      wr_en = wq; wr_idx = 3'(wi);
      wr_row = {AW'(wb), AW'(wt)}; wr_col = {AW'(wr), AW'(wl)}; wr_box_en = wen;
      if (v && r == 0 && c == 0) begin
         m_fcnt++;
         for (int i = 0; i < NB; i++)
            if (m_pend[i]) begin m_act[i] = m_sh[i]; m_pend[i] = 0; end
      end
      if (v) begin
         hit = 0;
         for (int i = 0; i < NB; i++) hit |= m_hit(i, r, c);
         q.push_back(hit ? LV : g);
      end
      if (wq && wi < NB) begin
         m_sh[wi] = '{wt, wb, wl, wr, wen}; m_pend[wi] = 1;
      end
      wq = 0;
   endtask

   always begin
      @(posedge clk); #1;
      if (rst) begin
         chk("amask", 32'(active_mask), 32'(m_mask()));
         if (out_valid) begin
            if (q.size() > 0) chk("pix", 32'(oBWrgb), 32'(q.pop_front()));
            else              chk("orphan_out", 32'(out_valid), 32'd0);
         end
      end
   end

   initial begin
      wq = 0; wi = 0; wt = 0; wb = 0; wl = 0; wr = 0; wen = 0;
      rst = 1'b0; in_valid = 0; Row = '0; Col = '0; GRAY2BW = '0;
      wr_en = 0; wr_idx = '0; wr_row = '0; wr_col = '0; wr_box_en = 0; blink_mask = '0;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix", 32'(oBWrgb), 0);
      chk("rst_vld", 32'(out_valid), 0);
      chk("rst_mask", 32'(active_mask), 0);
      @(negedge clk); rst = 1'b1;

      // No boxes: pure passthrough, with idle slots mixed in.
      drive(1, 0, 0);
      for (int i = 0; i < 40; i++) drive(($urandom_range(0, 3) != 0), $urandom_range(0, 479), $urandom_range(0, 639));

      // Box 0; not visible until the next frame start.
      wreq(0, 100, 200, 50, 150, 1); drive(1, 5, 5);
      drive(1, 100, 50);
      drive(1, 0, 0);
      drive(1, 100, 50); drive(1, 103, 120); drive(1, 197, 147);
      drive(1, 104, 54); drive(1, 99, 50);  drive(1, 200, 150); drive(1, 150, 146);
      for (int i = 0; i < 60; i++) drive(1, $urandom_range(90, 210), $urandom_range(40, 160));

      // Mid-frame write of box 1.
      wreq(1, 300, 320, 300, 340, 1); drive(1, 250, 250);
      drive(1, 300, 300); drive(1, 310, 339);
      drive(1, 0, 0);
      drive(1, 300, 300); drive(1, 310, 339); drive(1, 310, 320);

      // Write exactly on the commit pixel: box 2 waits a full frame.
      wreq(2, 400, 404, 400, 404, 1); drive(1, 0, 0);
      drive(1, 402, 402); drive(1, 1, 1);
      drive(1, 0, 0);
      for (int r = 399; r <= 405; r++) drive(1, r, 402);

      // Box hugging the top/left/right limits, then an inverted box.
      wreq(3, 0, 20, 0, 1023, 1); drive(1, 1, 1);
      drive(1, 0, 0);
      drive(1, 10, 500); drive(1, 10, 1020); drive(1, 10, 1019); drive(1, 10, 1023);
      drive(1, 2, 500);  drive(1, 25, 5);    drive(1, 19, 3);    drive(1, 10, 4);
      wreq(3, 10, 5, 0, 1023, 1); drive(1, 1, 1);
      wreq(7, 0, 1023, 0, 1023, 1); drive(1, 1, 2);
      drive(1, 0, 0);
      drive(1, 7, 500); drive(1, 10, 1023); drive(1, 5, 0); drive(1, 2, 500);
      for (int i = 0; i < 60; i++) drive(1, $urandom_range(0, 479), $urandom_range(0, 1023));

      // Asynchronous reset mid-frame; everything must be forgotten.
      drive(1, 150, 100);
      @(negedge clk); #2; rst = 1'b0; #1;
      chk("mrst_pix", 32'(oBWrgb), 0);
      chk("mrst_vld", 32'(out_valid), 0);
      chk("mrst_mask", 32'(active_mask), 0);
      m_clear();
      in_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      drive(1, 0, 0);
      drive(1, 100, 50); drive(1, 103, 120); drive(1, 402, 402);

`ifdef RECT_BLINK_EN
      blink_mask = 4'b0001;
      m_clear();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      wreq(0, 100, 200, 50, 150, 1); drive(1, 5, 5);
      for (int f = 0; f < 66; f++) begin
         drive(1, 0, 0); drive(1, 100, 60);
      end
`endif

      for (int i = 0; i < 4; i++) drive(0, 0, 0);
      chk("drain", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
